ifetch: RTL and testbench



---
 rtl/riscv.sv | 17 +
 rtl/ifetch_fifo.sv | 53 +++++
 rtl/ifetch.sv | 191 +++++++++++++++++++
 tb/tb_ifetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv.sv
// Shared core definitions used by the fetch stage.
package riscv;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } IFETCH_STATE;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] adr);
      return {adr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// In-order instruction queue: synchronous clear, push/pop, occupancy count.
module ifetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // storage needs no reset: only entries below count are ever presented
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: sequential fetch, in-order response queue, redirect flush.
// Optional IFETCH_ACCESS_FAULT_EN adds per-entry access-fault tracking and instr_fault_o.
//
// state | meaning
// IDLE  | first cycle after reset, no requests
// RUN   | normal fetch
// DRAIN | redirect taken, older responses still being discarded
module ifetch
   import riscv::*;
#(
   parameter int              FIFO_DEPTH   = 4,
   parameter int              MAX_OUTST    = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_adr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            imem_err_i,
   input  logic            flush_v_i,
   input  logic [XLEN-1:0] flush_pc_i,
   output logic            instr_v_o,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   input  logic            instr_ready_i
`ifdef IFETCH_ACCESS_FAULT_EN
   ,
   output logic            instr_fault_o
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = CW + 1;
`ifdef IFETCH_ACCESS_FAULT_EN
   localparam int EW = 2 * XLEN + 1;
`else
   localparam int EW = 2 * XLEN;
`endif

   IFETCH_STATE     state, state_n;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] rsp_pc;
   logic [XLEN-1:0] hold_adr;
   logic            hold_v;
   logic            hold_squash;
   logic [CW-1:0]   outst, outst_n;
   logic [CW-1:0]   discard, discard_n;
   logic [XLEN-1:0] last_instr;
   logic [XLEN-1:0] last_pc;

   logic            can_issue;
   logic            grant;
   logic            squash_grant;
   logic            rsp;
   logic            fault_block;

   logic            q_push;
   logic            q_pop;
   logic [EW-1:0]   q_wdata;
   logic [EW-1:0]   q_rdata;
   logic [CW-1:0]   q_count;
   logic            q_empty;
   logic            q_full;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_instr;

   // slots reserved for in-flight requests guarantee every response a queue entry
   assign can_issue = (state != IDLE) && !fault_block
                      && (outst < CW'(MAX_OUTST))
                      && ((SW'(q_count) + SW'(outst)) < SW'(FIFO_DEPTH));

   assign imem_req_o   = hold_v | can_issue;
   assign imem_adr_o   = hold_v ? hold_adr : word_align(fetch_pc);
   assign grant        = imem_req_o & imem_gnt_i;
   assign squash_grant = grant & hold_v & hold_squash;
   assign rsp          = imem_rvalid_i & (outst != '0);

   assign q_push  = rsp & ~flush_v_i & (discard == '0);
   assign q_pop   = ~q_empty & instr_ready_i & ~flush_v_i;
   assign outst_n = outst + CW'(grant) - CW'(rsp);

   // a flush writes off everything in flight; a held squashed request joins on grant
   assign discard_n = flush_v_i ? outst_n
                    : discard - CW'(rsp && (discard != '0)) + CW'(squash_grant);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = RUN;
         RUN:     if (flush_v_i && (discard_n != '0)) state_n = DRAIN;
         DRAIN:   if (discard_n == '0) state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         fetch_pc    <= word_align(RESET_VECTOR);
         rsp_pc      <= word_align(RESET_VECTOR);
         hold_adr    <= '0;
         hold_v      <= 1'b0;
         hold_squash <= 1'b0;
         outst       <= '0;
         discard     <= '0;
         last_instr  <= '0;
         last_pc     <= '0;
      end else begin
         state       <= state_n;
         outst       <= outst_n;
         discard     <= discard_n;
         hold_v      <= imem_req_o & ~imem_gnt_i;
         hold_squash <= imem_req_o & ~imem_gnt_i & (flush_v_i | (hold_v & hold_squash));
         if (imem_req_o && !imem_gnt_i) hold_adr <= imem_adr_o;
         if (flush_v_i)
            fetch_pc <= word_align(flush_pc_i);
         else if (grant && !squash_grant)
            fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
         if (flush_v_i)
            rsp_pc <= word_align(flush_pc_i);
         else if (q_push)
            rsp_pc <= rsp_pc + XLEN'(INSTR_BYTES);
         if (!q_empty) begin
            last_instr <= head_instr;
            last_pc    <= head_pc;
         end
      end
   end

`ifdef IFETCH_ACCESS_FAULT_EN
   logic head_flt;
   logic last_flt;

   assign q_wdata       = {rsp_pc, imem_rdata_i & {XLEN{~imem_err_i}}, imem_err_i};
   assign head_pc       = q_rdata[EW-1 -: XLEN];
   assign head_instr    = q_rdata[XLEN:1];
   assign head_flt      = q_rdata[0];
   assign instr_fault_o = q_empty ? last_flt : head_flt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_block <= 1'b0;
         last_flt    <= 1'b0;
      end else begin
         if (flush_v_i)
            fault_block <= 1'b0;
         else if (q_push && imem_err_i)
            fault_block <= 1'b1;
         if (!q_empty) last_flt <= head_flt;
      end
   end
`else
   logic unused_err;

   assign unused_err  = imem_err_i;
   assign fault_block = 1'b0;
   assign q_wdata     = {rsp_pc, imem_rdata_i};
   assign head_pc     = q_rdata[EW-1 -: XLEN];
   assign head_instr  = q_rdata[XLEN-1:0];
`endif

   assign instr_v_o = ~q_empty;
   assign instr_o   = q_empty ? last_instr : head_instr;
   assign pc_o      = q_empty ? last_pc : head_pc;

   ifetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush_v_i),
      .push    (q_push),
      .pop     (q_pop),
      .wdata   (q_wdata),
      .rdata   (q_rdata),
      .count   (q_count),
      .empty   (q_empty),
      .full    (q_full)
   );

   a_rsp_with_outst: assert property (@(posedge clk) disable iff (!reset_n)
      imem_rvalid_i |-> (outst != '0));

   a_push_has_room: assert property (@(posedge clk) disable iff (!reset_n)
      q_push |-> !q_full);

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: cycle table, directed corner sequences and a randomized run
// against a sequential-stream reference model.
module tb_ifetch;
   import riscv::*;

   localparam int FIFO_DEPTH = 4;
   localparam int MAX_OUTST  = 2;
   localparam int NV         = 11;

   logic            clk;
   logic            reset_n;
   logic            imem_req_o;
   logic [31:0]     imem_adr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [31:0]     imem_rdata_i;
   logic            imem_err_i;
   logic            flush_v_i;
   logic [31:0]     flush_pc_i;
   logic            instr_v_o;
   logic [31:0]     instr_o;
   logic [31:0]     pc_o;
   logic            instr_ready_i;
`ifdef IFETCH_ACCESS_FAULT_EN
   logic            instr_fault_o;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ifetch #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .MAX_OUTST    (MAX_OUTST),
      .RESET_VECTOR (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req_o    (imem_req_o),
      .imem_adr_o    (imem_adr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .imem_err_i    (imem_err_i),
      .flush_v_i     (flush_v_i),
      .flush_pc_i    (flush_pc_i),
      .instr_v_o     (instr_v_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .instr_ready_i (instr_ready_i)
`ifdef IFETCH_ACCESS_FAULT_EN
      ,
      .instr_fault_o (instr_fault_o)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic        flush;
      logic [31:0] fpc;
      logic        e_req;
      logic [31:0] e_adr;
      logic        e_v;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vt [NV];

   typedef struct {
      logic [31:0] adr;
      int          due;
   } rsp_t;

   rsp_t        rsp_q [$];
   logic [31:0] gnt_log [$];
   int          cyc;
   int          n_acc;
   logic [31:0] exp_pc;
   logic        prev_hold;
   logic [31:0] prev_adr;
   logic        prev_flush;
   int          gnt_pct;
   int          rdy_pct;
   int          lat_min;
   int          lat_max;
   logic        flush_req;
   logic [31:0] flush_tgt;
   logic        fault_on;
   logic [31:0] fault_adr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return (fault_on && a == fault_adr) ? 32'h0 : mem_word(a);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n       = 1'b0;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      imem_err_i    = 1'b0;
      flush_v_i     = 1'b0;
      flush_pc_i    = '0;
      instr_ready_i = 1'b0;
      #1;
      check("rst_req", imem_req_o, 0);
      check("rst_v", instr_v_o, 0);
      check("rst_pc", pc_o, 0);
      check("rst_instr", instr_o, 0);
      rsp_q.delete();
      gnt_log.delete();
      cyc        = 0;
      n_acc      = 0;
      exp_pc     = 32'h0;
      prev_hold  = 1'b0;
      prev_adr   = '0;
      prev_flush = 1'b0;
      flush_req  = 1'b0;
      fault_on   = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // one cycle of memory model, decoder model and stream checks
   task automatic run_cycle();
      rsp_t r;
      @(negedge clk);
      cyc++;
      imem_gnt_i = ($urandom_range(99) < gnt_pct);
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
         r = rsp_q.pop_front();
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(r.adr);
         imem_err_i    = fault_on && (r.adr == fault_adr);
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
         imem_err_i    = 1'b0;
      end
      instr_ready_i = ($urandom_range(99) < rdy_pct);
      flush_v_i     = flush_req;
      flush_pc_i    = flush_tgt;
      flush_req     = 1'b0;
      #1;
      if (prev_hold) begin
         check("req_stable", imem_req_o, 1);
         check("adr_stable", imem_adr_o, prev_adr);
      end
      if (prev_flush) check("v_after_flush", instr_v_o, 0);
      if (imem_req_o && imem_gnt_i) begin
         rsp_q.push_back('{imem_adr_o, cyc + int'($urandom_range(lat_max, lat_min))});
         gnt_log.push_back(imem_adr_o);
      end
      check("outstanding_max", rsp_q.size() <= MAX_OUTST, 1);
      if (flush_v_i) begin
         exp_pc = {flush_pc_i[31:2], 2'b00};
      end else if (instr_v_o && instr_ready_i) begin
         check("acc_pc", pc_o, exp_pc);
         check("acc_instr", instr_o, exp_word(exp_pc));
`ifdef IFETCH_ACCESS_FAULT_EN
         check("acc_fault", instr_fault_o, fault_on && exp_pc == fault_adr);
`endif
         exp_pc += 32'd4;
         n_acc++;
      end
      prev_hold  = imem_req_o && !imem_gnt_i;
      prev_adr   = imem_adr_o;
      prev_flush = flush_v_i;
   endtask

   int k;

   initial begin
      // gnt rvalid rdata ready flush fpc | req adr v pc instr
      vt[0]  = '{1, 0, 32'h0,         1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0};
      vt[1]  = '{1, 0, 32'h0,         1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0};
      vt[2]  = '{1, 1, 32'hC0DE_0000, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0,   32'h0};
      vt[3]  = '{1, 1, 32'hC0DE_0004, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0,   32'hC0DE_0000};
      vt[4]  = '{1, 1, 32'hC0DE_0008, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4,   32'hC0DE_0004};
      vt[5]  = '{1, 1, 32'hC0DE_000C, 1, 1, 32'h201, 1, 32'h10,  1, 32'h8,   32'hC0DE_0008};
      vt[6]  = '{0, 1, 32'hBAD0_0010, 1, 0, 32'h0,   1, 32'h200, 0, 32'h8,   32'hC0DE_0008};
      vt[7]  = '{1, 0, 32'h0,         1, 0, 32'h0,   1, 32'h200, 0, 32'h8,   32'hC0DE_0008};
      vt[8]  = '{0, 1, 32'hC0DE_0200, 1, 0, 32'h0,   1, 32'h204, 0, 32'h8,   32'hC0DE_0008};
      vt[9]  = '{0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h204, 1, 32'h200, 32'hC0DE_0200};
      vt[10] = '{0, 0, 32'h0,         1, 0, 32'h0,   1, 32'h204, 0, 32'h200, 32'hC0DE_0200};

      reset_n = 1'b0;
      lat_min = 1;
      lat_max = 1;
      gnt_pct = 100;
      rdy_pct = 100;
      flush_tgt = '0;
      fault_adr = '0;
      do_reset();

      for (int i = 0; i < NV; i++) begin
         imem_gnt_i    = vt[i].gnt;
         imem_rvalid_i = vt[i].rvalid;
         imem_rdata_i  = vt[i].rdata;
         imem_err_i    = 1'b0;
         instr_ready_i = vt[i].ready;
         flush_v_i     = vt[i].flush;
         flush_pc_i    = vt[i].fpc;
         #1;
         check($sformatf("vec%0d_req", i), imem_req_o, vt[i].e_req);
         if (vt[i].e_req) check($sformatf("vec%0d_adr", i), imem_adr_o, vt[i].e_adr);
         check($sformatf("vec%0d_v", i), instr_v_o, vt[i].e_v);
         check($sformatf("vec%0d_pc", i), pc_o, vt[i].e_pc);
         check($sformatf("vec%0d_instr", i), instr_o, vt[i].e_instr);
         @(negedge clk);
      end

      // reset with a held request pending, then fill with decode stalled
      do_reset();
      gnt_pct = 100; rdy_pct = 0; lat_min = 1; lat_max = 1;
      repeat (20) run_cycle();
      check("fill_grants", gnt_log.size(), FIFO_DEPTH);
      check("fill_req_off", imem_req_o, 0);
      rdy_pct = 100;
      for (int i = 0; i < 40 && n_acc < 8; i++) run_cycle();
      check("fill_drain_count", n_acc >= 8, 1);

      // grant stall with a redirect in the middle
      do_reset();
      gnt_pct = 0; rdy_pct = 100;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            flush_req = 1'b1;
            flush_tgt = 32'h100;
         end
         run_cycle();
         check("stall_req", imem_req_o, 1);
         check("stall_adr", imem_adr_o, 32'h0);
      end
      gnt_pct = 100;
      for (int i = 0; i < 30 && n_acc < 3; i++) run_cycle();
      check("stall_acc", n_acc >= 3, 1);
      if (gnt_log.size() >= 2) begin
         check("stall_first_gnt", gnt_log[0], 32'h0);
         check("stall_next_gnt", gnt_log[1], 32'h100);
      end else begin
         check("stall_gnt_count", gnt_log.size(), 2);
      end

      // two requests in flight when the redirect arrives
      do_reset();
      gnt_pct = 100; rdy_pct = 100; lat_min = 4; lat_max = 4;
      for (int i = 0; i < 10 && rsp_q.size() < 2; i++) run_cycle();
      check("inflight_two", rsp_q.size(), 2);
      k = gnt_log.size();
      flush_req = 1'b1;
      flush_tgt = 32'h2002;
      run_cycle();
      for (int i = 0; i < 40 && n_acc < 2; i++) run_cycle();
      check("inflight_acc", n_acc >= 2, 1);
      if (gnt_log.size() > k) check("inflight_next_gnt", gnt_log[k], 32'h2000);
      else check("inflight_gnt_count", gnt_log.size(), k + 1);

`ifdef IFETCH_ACCESS_FAULT_EN
      // access fault on 0x8 blocks fetch until a redirect
      do_reset();
      fault_on = 1'b1; fault_adr = 32'h8;
      gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
      repeat (15) run_cycle();
      check("fault_acc", n_acc, 4);
      check("fault_grants", gnt_log.size(), 4);
      check("fault_req_off", imem_req_o, 0);
      k = gnt_log.size();
      flush_req = 1'b1;
      flush_tgt = 32'h40;
      run_cycle();
      for (int i = 0; i < 20 && n_acc < 6; i++) run_cycle();
      check("fault_resume_acc", n_acc >= 6, 1);
      if (gnt_log.size() > k) check("fault_resume_gnt", gnt_log[k], 32'h40);
      else check("fault_resume_count", gnt_log.size(), k + 1);
`endif

      // randomized traffic with redirects, starting near the address wrap
      do_reset();
      gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 3;
      flush_req = 1'b1;
      flush_tgt = 32'hFFFF_FFF8;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 3) begin
            flush_req = 1'b1;
            flush_tgt = $urandom();
         end
         run_cycle();
      end
      k = n_acc;
      gnt_pct = 100; rdy_pct = 100;
      repeat (40) run_cycle();
      check("random_live", (n_acc - k) >= 20, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
